// File: rtl/backtrack_controller.sv
// Conflict backtrack engine for the DPLL core.
// Pops the trace, unassigns forced vars, flips the last decision.
module backtrack_controller #(
    parameter int NUM_VARIABLE   = 128,
    parameter int VAR_W          = 9,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int PC_W          = $clog2(NUM_VARIABLE + 1),
    localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             tt_push,
    output logic             tt_pop,
    output logic             tt_type,
    output logic             tt_val,
    output logic [VAR_W-1:0] tt_variable,
    input  logic             tt_done,
    input  logic             tt_empty,
    input  logic             tt_type_out,
    input  logic             tt_val_out,
    input  logic [VAR_W-1:0] tt_variable_out,
    output logic             var_wr_en,
    output logic [VAR_W-1:0] var_wr_idx,
    output logic [1:0]       var_wr_val,
    output logic             busy,
    output logic             done,
    output logic             unsat,
    output logic             error,
    output logic [VAR_W-1:0] flipped_var,
    output logic             flipped_val,
    output logic [PC_W-1:0]  pop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_REQ,
        S_POP_WAIT,
        S_UNASSIGN,
        S_PUSH_REQ,
        S_PUSH_WAIT,
        S_FINISH
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_MAX  = PC_W'(NUM_VARIABLE);

    state_t           r_state;
    logic [TO_W-1:0]  r_tmo;
    logic             r_typ;
    logic             r_val;
    logic [VAR_W-1:0] r_var;

    logic             r_tt_push;
    logic             r_tt_pop;
    logic             r_tt_type;
    logic             r_tt_val;
    logic [VAR_W-1:0] r_tt_var;
    logic             r_wr_en;
    logic [VAR_W-1:0] r_wr_idx;
    logic [1:0]       r_wr_val;
    logic             r_busy;
    logic             r_done;
    logic             r_unsat;
    logic             r_error;
    logic [VAR_W-1:0] r_flip_var;
    logic             r_flip_val;
    logic [PC_W-1:0]  r_pop_count;

    // Backtrack FSM; every output is registered on entry to its state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tmo       <= '0;
            r_typ       <= 1'b0;
            r_val       <= 1'b0;
            r_var       <= '0;
            r_tt_push   <= 1'b0;
            r_tt_pop    <= 1'b0;
            r_tt_type   <= 1'b0;
            r_tt_val    <= 1'b0;
            r_tt_var    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_val    <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_unsat     <= 1'b0;
            r_error     <= 1'b0;
            r_flip_var  <= '0;
            r_flip_val  <= 1'b0;
            r_pop_count <= '0;
        end else begin
            r_tt_push <= 1'b0;
            r_tt_pop  <= 1'b0;
            r_tt_type <= 1'b0;
            r_tt_val  <= 1'b0;
            r_tt_var  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_val  <= 2'b00;
            r_done    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_POP_REQ;
                        r_tt_pop    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pop_count <= '0;
                        r_unsat     <= 1'b0;
                        r_error     <= 1'b0;
                    end
                end
                S_POP_REQ: begin
                    r_state <= S_POP_WAIT;
                    r_tmo   <= '0;
                end
                S_POP_WAIT: begin
                    if (tt_done) begin
                        if (tt_empty) begin
                            r_unsat <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_typ    <= tt_type_out;
                            r_val    <= tt_val_out;
                            r_var    <= tt_variable_out;
                            r_wr_en  <= 1'b1;
                            r_wr_idx <= tt_variable_out;
                            r_state  <= S_UNASSIGN;
                            if (r_pop_count != PC_MAX) begin
                                r_pop_count <= r_pop_count + 1'b1;
                            end
                        end
                    end else if (r_tmo == TO_LAST) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_UNASSIGN: begin
                    if (r_typ) begin
                        r_state  <= S_POP_REQ;
                        r_tt_pop <= 1'b1;
                    end else begin
                        r_state   <= S_PUSH_REQ;
                        r_tt_push <= 1'b1;
                        r_tt_type <= 1'b1;
                        r_tt_val  <= ~r_val;
                        r_tt_var  <= r_var;
                        r_wr_en   <= 1'b1;
                        r_wr_idx  <= r_var;
                        r_wr_val  <= r_val ? 2'b01 : 2'b10;
                    end
                end
                S_PUSH_REQ: begin
                    r_state <= S_PUSH_WAIT;
                    r_tmo   <= '0;
                end
                S_PUSH_WAIT: begin
                    if (tt_done) begin
                        r_flip_var <= r_var;
                        r_flip_val <= ~r_val;
                        r_done     <= 1'b1;
                        r_state    <= S_FINISH;
                    end else if (r_tmo == TO_LAST) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tt_push     = r_tt_push;
    assign tt_pop      = r_tt_pop;
    assign tt_type     = r_tt_type;
    assign tt_val      = r_tt_val;
    assign tt_variable = r_tt_var;
    assign var_wr_en   = r_wr_en;
    assign var_wr_idx  = r_wr_idx;
    assign var_wr_val  = r_wr_val;
    assign busy        = r_busy;
    assign done        = r_done;
    assign unsat       = r_unsat;
    assign error       = r_error;
    assign flipped_var = r_flip_var;
    assign flipped_val = r_flip_val;
    assign pop_count   = r_pop_count;

endmodule

// File: tb/tb_backtrack_controller.sv
// Bench for backtrack_controller: trace-table responder,
// table vectors, hand sequences and random traces vs a model.
module tb_backtrack_controller;

    typedef struct packed {
        logic       typ;
        logic       val;
        logic [8:0] vidx;
    } ent_t;

    typedef struct {
        int         n;
        ent_t       e[4];
        logic [8:0] fv;
        logic       fval;
        int         pc;
        bit         un;
        int         restart;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       tt_push, tt_pop, tt_type, tt_val;
    logic [8:0] tt_variable;
    logic       tt_done, tt_empty, tt_type_out, tt_val_out;
    logic [8:0] tt_variable_out;
    logic       var_wr_en;
    logic [8:0] var_wr_idx;
    logic [1:0] var_wr_val;
    logic       busy, done, unsat, error;
    logic [8:0] flipped_var;
    logic       flipped_val;
    logic [7:0] pop_count;

    backtrack_controller dut (
        .clk(clk), .reset(reset), .start(start),
        .tt_push(tt_push), .tt_pop(tt_pop), .tt_type(tt_type),
        .tt_val(tt_val), .tt_variable(tt_variable),
        .tt_done(tt_done), .tt_empty(tt_empty),
        .tt_type_out(tt_type_out), .tt_val_out(tt_val_out),
        .tt_variable_out(tt_variable_out),
        .var_wr_en(var_wr_en), .var_wr_idx(var_wr_idx),
        .var_wr_val(var_wr_val), .busy(busy), .done(done),
        .unsat(unsat), .error(error), .flipped_var(flipped_var),
        .flipped_val(flipped_val), .pop_count(pop_count)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    // responder / observation state
    ent_t        trace[$];
    int          cyc;
    int          rsp_delay = 1;
    bit          hold_pop = 0, hold_push = 0;
    bit          pend;
    bit          pend_push;
    int          due;
    ent_t        push_ent;
    logic [10:0] wr_q[$];
    ent_t        push_q[$];
    int          pop_reqs, proto_err, busy_err, done_cyc;
    bit          done_seen;

    // model expectations
    logic [10:0] ewr[$];
    ent_t        epush[$];
    ent_t        etr[$];
    int          ecyc, epc;
    bit          eun;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
        nchk++;
        if (act === exp_v) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    endtask

    function automatic ent_t mk(input logic t, input logic v,
                                input int x);
        ent_t e;
        e.typ = t;
        e.val = v;
        e.vidx = 9'(x);
        return e;
    endfunction

    function automatic logic [63:0] all_outs();
        return {17'd0, tt_push, tt_pop, tt_type, tt_val, tt_variable,
                var_wr_en, var_wr_idx, var_wr_val, busy, done, unsat,
                error, flipped_var, flipped_val, pop_count};
    endfunction

    task automatic clear_obs();
        wr_q.delete();
        push_q.delete();
        pop_reqs = 0;
        proto_err = 0;
        busy_err = 0;
        done_seen = 0;
        done_cyc = -1;
        pend = 0;
    endtask

    // one cycle: observe DUT at negedge, then drive trace-table inputs
    task automatic tick();
        ent_t e;
        @(negedge clk);
        cyc++;
        tt_done = 0;
        tt_empty = 0;
        tt_type_out = 0;
        tt_val_out = 0;
        tt_variable_out = '0;
        if (var_wr_en) wr_q.push_back({var_wr_idx, var_wr_val});
        if (tt_push) push_q.push_back(ent_t'({tt_type, tt_val, tt_variable}));
        if (tt_pop) pop_reqs++;
        if (tt_push && tt_pop) proto_err++;
        if (!tt_push && ({tt_type, tt_val, tt_variable} != 0)) proto_err++;
        if (done && !done_seen) begin
            done_seen = 1;
            done_cyc = cyc;
        end
        if (pend && cyc == due) begin
            pend = 0;
            tt_done = 1;
            if (pend_push) begin
                trace.push_back(push_ent);
            end else if (trace.size() == 0) begin
                tt_empty = 1;
            end else begin
                e = trace.pop_back();
                tt_type_out = e.typ;
                tt_val_out = e.val;
                tt_variable_out = e.vidx;
            end
        end
        if (tt_pop && !hold_pop) begin
            pend = 1;
            pend_push = 0;
            due = cyc + rsp_delay;
        end
        if (tt_push && !hold_push) begin
            pend = 1;
            pend_push = 1;
            push_ent = ent_t'({tt_type, tt_val, tt_variable});
            due = cyc + rsp_delay;
        end
    endtask

    // expected backtrack outcome straight from the trace contents
    task automatic model(input int d);
        ent_t e;
        int attempts;
        etr = trace;
        ewr.delete();
        epush.delete();
        eun = 0;
        epc = 0;
        attempts = 0;
        while (1) begin
            attempts++;
            if (etr.size() == 0) begin
                eun = 1;
                break;
            end
            e = etr.pop_back();
            epc++;
            ewr.push_back({e.vidx, 2'b00});
            if (e.typ == 1'b0) begin
                ewr.push_back({e.vidx, e.val ? 2'b01 : 2'b10});
                epush.push_back(mk(1'b1, ~e.val, int'(e.vidx)));
                etr.push_back(mk(1'b1, ~e.val, int'(e.vidx)));
                break;
            end
        end
        if (epc > 128) epc = 128;
        ecyc = attempts * (1 + d) + epc + epush.size() * (1 + d) + 1;
    endtask

    task automatic run_bt(input int d, input int restart_at);
        rsp_delay = d;
        tick();
        clear_obs();
        cyc = 0;
        start = 1;
        while (!done_seen && cyc < 400) begin
            tick();
            start = (cyc == restart_at);
            if (!busy) busy_err++;
        end
        chk("run.done_seen", done_seen, 1);
        tick();
        start = 0;
        chk("run.busy_after", busy, 0);
        chk("run.idle_pop", tt_pop, 0);
    endtask

    task automatic check_run(input string tag);
        chk({tag, ".done_cyc"}, done_cyc, ecyc);
        chk({tag, ".unsat"}, unsat, eun);
        chk({tag, ".error"}, error, 0);
        chk({tag, ".pop_count"}, pop_count, epc);
        if (!eun) begin
            chk({tag, ".flip_var"}, flipped_var, epush[0].vidx);
            chk({tag, ".flip_val"}, flipped_val, epush[0].val);
        end
        chk({tag, ".n_wr"}, wr_q.size(), ewr.size());
        for (int i = 0; i < ewr.size() && i < wr_q.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), wr_q[i], ewr[i]);
        chk({tag, ".n_push"}, push_q.size(), epush.size());
        for (int i = 0; i < epush.size() && i < push_q.size(); i++)
            chk($sformatf("%s.push%0d", tag, i), push_q[i], epush[i]);
        chk({tag, ".trace_n"}, trace.size(), etr.size());
        for (int i = 0; i < etr.size() && i < trace.size(); i++)
            chk($sformatf("%s.trace%0d", tag, i), trace[i], etr[i]);
        chk({tag, ".proto"}, proto_err, 0);
        chk({tag, ".busy"}, busy_err, 0);
    endtask

    task automatic load_vec(input int i);
        trace.delete();
        for (int j = 0; j < vecs[i].n; j++) trace.push_back(vecs[i].e[j]);
    endtask

    initial begin
        logic [63:0] held;
        int pulses;
        string tag;

        // trace listed bottom first; last entry is popped first
        vecs[0].n = 1; vecs[0].e[0] = mk(0, 1, 5);
        vecs[0].fv = 5; vecs[0].fval = 0; vecs[0].pc = 1;
        vecs[0].un = 0; vecs[0].restart = -1;
        vecs[1].n = 3; vecs[1].e[0] = mk(0, 0, 3);
        vecs[1].e[1] = mk(1, 1, 7); vecs[1].e[2] = mk(1, 0, 9);
        vecs[1].fv = 3; vecs[1].fval = 1; vecs[1].pc = 3;
        vecs[1].un = 0; vecs[1].restart = 2;
        vecs[2].n = 1; vecs[2].e[0] = mk(1, 1, 2);
        vecs[2].fv = 0; vecs[2].fval = 0; vecs[2].pc = 1;
        vecs[2].un = 1; vecs[2].restart = -1;
        vecs[3].n = 0;
        vecs[3].fv = 0; vecs[3].fval = 0; vecs[3].pc = 0;
        vecs[3].un = 1; vecs[3].restart = -1;
        vecs[4].n = 3; vecs[4].e[0] = mk(1, 0, 4);
        vecs[4].e[1] = mk(0, 0, 8); vecs[4].e[2] = mk(1, 1, 1);
        vecs[4].fv = 8; vecs[4].fval = 1; vecs[4].pc = 2;
        vecs[4].un = 0; vecs[4].restart = -1;

        reset = 1;
        start = 0;
        tt_done = 0;
        tt_empty = 0;
        tt_type_out = 0;
        tt_val_out = 0;
        tt_variable_out = '0;
        cyc = 0;
        clear_obs();
        repeat (3) tick();
        chk("reset.outs", all_outs(), 0);
        reset = 0;
        tick();

        // table vectors
        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("vec%0d", i);
            load_vec(i);
            model(1);
            run_bt(1, vecs[i].restart);
            chk({tag, ".t_unsat"}, unsat, vecs[i].un);
            chk({tag, ".t_pc"}, pop_count, vecs[i].pc);
            if (!vecs[i].un) begin
                chk({tag, ".t_fv"}, flipped_var, vecs[i].fv);
                chk({tag, ".t_fval"}, flipped_val, vecs[i].fval);
            end
            check_run(tag);
        end

        // pop response withheld: timeout, no writes
        load_vec(0);
        hold_pop = 1;
        run_bt(1, -1);
        hold_pop = 0;
        chk("pop_to.error", error, 1);
        chk("pop_to.done_cyc", done_cyc, 66);
        chk("pop_to.n_wr", wr_q.size(), 0);
        chk("pop_to.n_push", push_q.size(), 0);
        chk("pop_to.pc", pop_count, 0);
        chk("pop_to.unsat", unsat, 0);

        // push response withheld: timeout after the flip push
        load_vec(0);
        hold_push = 1;
        run_bt(1, -1);
        hold_push = 0;
        chk("push_to.error", error, 1);
        chk("push_to.done_cyc", done_cyc, 69);
        chk("push_to.n_wr", wr_q.size(), 2);
        chk("push_to.n_push", push_q.size(), 1);
        chk("push_to.pc", pop_count, 1);

        // reset asserted while waiting for push completion
        load_vec(0);
        hold_push = 1;
        tick();
        clear_obs();
        cyc = 0;
        start = 1;
        while (cyc < 20 && push_q.size() == 0) begin
            tick();
            start = 0;
        end
        chk("rst.push_cyc", cyc, 4);
        tick();
        reset = 1;
        tick();
        chk("rst.outs", all_outs(), 0);
        reset = 0;
        hold_push = 0;
        clear_obs();
        repeat (5) tick();
        chk("rst.quiet", pop_reqs + push_q.size() + wr_q.size()
                         + int'(done_seen) + int'(busy), 0);
        load_vec(1);
        model(1);
        run_bt(1, ecyc);
        check_run("after_rst");

        // stray tt_done while idle
        held = {unsat, error, flipped_var, flipped_val, pop_count};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(tt_push) + int'(tt_pop) + int'(var_wr_en)
                      + int'(done) + int'(busy);
            tt_done = 1;
            tt_empty = 1'($urandom);
            tt_type_out = 1'($urandom);
            tt_val_out = 1'($urandom);
            tt_variable_out = 9'($urandom);
        end
        tick();
        pulses += int'(tt_push) + int'(tt_pop) + int'(var_wr_en)
                  + int'(done) + int'(busy);
        chk("stray.pulses", pulses, 0);
        chk("stray.held", {unsat, error, flipped_var, flipped_val,
                           pop_count}, held);

        // random traces and trace-table latencies
        for (int r = 0; r < 25; r++) begin
            int n, d;
            n = $urandom_range(0, 8);
            d = $urandom_range(1, 3);
            trace.delete();
            for (int j = 0; j < n; j++)
                trace.push_back(mk($urandom_range(0, 3) != 0,
                                   1'($urandom), $urandom_range(0, 511)));
            model(d);
            run_bt(d, -1);
            check_run($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/backtrack_controller.md
Name: backtrack_controller

Overview:
- Conflict-driven backtrack engine for the DPLL core; the initiator that drives the trace table's push/pop interface.
- On a conflict it pops trace entries and unassigns each forced variable in the assignment memory.
- When it reaches the most recent decision, it flips that decision and pushes it back onto the trace as a forced entry.
- Reports UNSAT if the trace runs empty before any decision is found.

Parameters:
- NUM_VARIABLE, 128, maximum variables held in the trace; bounds pop_count.
- VAR_W, 9, width of a variable index.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for tt_done before aborting with error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle conflict pulse from the clause evaluator
- tt_push  out  1  single-cycle push request to the trace table
- tt_pop  out  1  single-cycle pop request to the trace table
- tt_type  out  1  pushed entry type (D=0/F=1); always 1 from this block
- tt_val  out  1  pushed assigned value
- tt_variable  out  VAR_W  pushed variable index
- tt_done  in  1  trace table completion strobe for a push or pop
- tt_empty  in  1  valid with tt_done on a pop; the trace held no entry
- tt_type_out  in  1  popped entry type
- tt_val_out  in  1  popped entry value
- tt_variable_out  in  VAR_W  popped variable index
- var_wr_en  out  1  assignment memory write strobe
- var_wr_idx  out  VAR_W  assignment memory address
- var_wr_val  out  2  assignment code: 00 unassigned, 01 false, 10 true
- busy  out  1  high from the cycle after an accepted start until the cycle after done
- done  out  1  single-cycle completion pulse
- unsat  out  1  valid with done; trace exhausted
- error  out  1  valid with done; handshake timeout
- flipped_var  out  VAR_W  valid with done when unsat=0 and error=0
- flipped_val  out  1  new value of flipped_var
- pop_count  out  $clog2(NUM_VARIABLE+1)  entries popped in this backtrack; saturates at NUM_VARIABLE

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - All outputs 0, including pop_count, flipped_var, flipped_val and the timeout counter.
  - Reset asserted mid-operation aborts immediately; no further push, pop or write is issued.
- IDLE:
  - start=1 → POP_REQ; pop_count, unsat and error cleared.
  - start while busy=1 is ignored.
- POP_REQ: tt_pop=1 for exactly one cycle → POP_WAIT.
- POP_WAIT:
  - Timeout counter increments each cycle.
  - On tt_done with tt_empty=1 → FINISH, unsat=1.
  - On tt_done with tt_empty=0:
    - Latch type, val and variable.
    - pop_count+1, saturating.
    - → UNASSIGN.
  - Counter reaches TIMEOUT_CYCLES without tt_done → FINISH, error=1.
- UNASSIGN:
  - var_wr_en=1, var_wr_idx=latched variable, var_wr_val=00 for one cycle.
  - Latched type=1 (forced) → POP_REQ.
  - Latched type=0 (decision) → PUSH_REQ.
- PUSH_REQ:
  - tt_push=1, tt_type=1, tt_val=~latched val, tt_variable=latched variable, all for one cycle.
  - Same cycle: var_wr_en=1, var_wr_idx=latched variable, var_wr_val = (~val ? 10 : 01).
  - → PUSH_WAIT.
- PUSH_WAIT:
  - tt_done → FINISH; flipped_var and flipped_val are loaded.
  - Timeout → FINISH, error=1.
- FINISH: done=1 for one cycle → IDLE.
- Request outputs: tt_push/tt_pop and their data are 0 in every state except their request state; the two are never high together.
- Timeout counter: cleared on entry to each WAIT state.
- tt_done arriving in any state other than POP_WAIT or PUSH_WAIT is ignored.
- Latency, with start seen in cycle 0 and a 1-cycle trace response:
  - tt_pop in cycle 1.
  - Each forced entry costs 3 cycles (POP_REQ, POP_WAIT, UNASSIGN).
  - Decision flip adds PUSH_REQ, PUSH_WAIT and FINISH.
- Outputs unsat, error, flipped_var, flipped_val and pop_count hold their values until the next accepted start.

Test Plan:
- Trace = [D var5 val1]; start → one pop; write idx5 code 00, then code 01; push {type1, val0, var5}; done with flipped_var=5, flipped_val=0, pop_count=1.
- Trace = [D var3 val0, F var7 val1, F var9 val0]; start → unassign 9, then 7, then 3; push {type1, val1, var3}; pop_count=3; unsat=0.
- Trace = [F var2 val1]; start → unassign 2; second pop returns tt_empty=1; done with unsat=1, pop_count=1, and no push issued.
- tt_done withheld 64 cycles after tt_pop → done with error=1; no var_wr_en issued.
- start re-pulsed while busy, and reset asserted in PUSH_WAIT → the extra start is ignored; after reset all outputs are 0 and state is IDLE; a new start then runs normally.
- Stray tt_done pulses while in IDLE → no state change and no outputs asserted.
